// File: rtl/bram_mailbox_target_if.sv
`default_nettype none
// ============================================================================
// Module   : bram_mailbox_target_if
// Purpose  : Bundles the local put/get methods and the BRAM target wires of
//            the mailbox into one interface.
// Ports    : slave  - the mailbox target (receives put/get enables and the
//                     initiator's BRAM strobes, drives ready/data/bramDin)
//            master - local logic plus the BRAM initiator (the other side)
// Revision : 1.0  initial release
// ============================================================================
interface bram_mailbox_target_if;
  logic [31:0] msgInput_put;
  logic        EN_msgInput_put;
  logic        RDY_msgInput_put;
  logic        EN_msgOutput_get;
  logic [31:0] msgOutput_get;
  logic        RDY_msgOutput_get;
  logic        bramTargetWires_bramRST;
  logic [31:0] bramTargetWires_bramAddr;
  logic [31:0] bramTargetWires_bramDout;
  logic [3:0]  bramTargetWires_bramWEN;
  logic        bramTargetWires_bramEN;
  logic [31:0] bramTargetWires_bramDin;

  modport slave (
    input  msgInput_put, EN_msgInput_put, EN_msgOutput_get,
    input  bramTargetWires_bramRST, bramTargetWires_bramAddr,
    input  bramTargetWires_bramDout, bramTargetWires_bramWEN, bramTargetWires_bramEN,
    output RDY_msgInput_put, msgOutput_get, RDY_msgOutput_get,
    output bramTargetWires_bramDin
  );

  modport master (
    output msgInput_put, EN_msgInput_put, EN_msgOutput_get,
    output bramTargetWires_bramRST, bramTargetWires_bramAddr,
    output bramTargetWires_bramDout, bramTargetWires_bramWEN, bramTargetWires_bramEN,
    input  RDY_msgInput_put, msgOutput_get, RDY_msgOutput_get,
    input  bramTargetWires_bramDin
  );
endinterface
`default_nettype wire

// File: rtl/bram_mailbox_target.sv
`default_nettype none
// ============================================================================
// Module   : bram_mailbox_target
// Purpose  : BRAM-port responder exposing a four-word mailbox window:
//            0 DOWN_DATA (write push), 1 UP_DATA (read pop), 2 STATUS,
//            3 CONTROL. Down FIFO feeds the local get method, the local put
//            method feeds the up FIFO.
// Ports    : CLK   - sole clock (also the BRAM port clock)
//            RST_N - asynchronous active-low reset
//            bus   - bram_mailbox_target_if.slave (put/get + BRAM wires)
//            irq   - registered interrupt, only when MAILBOX_IRQ_EN defined
// Options  : `define MAILBOX_IRQ_EN adds irq and the CONTROL bit2 enable
// Revision : 1.0  initial release
// ============================================================================
module bram_mailbox_target #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 32
) (
  input  wire logic            CLK,
  input  wire logic            RST_N,
  bram_mailbox_target_if.slave bus
`ifdef MAILBOX_IRQ_EN
  ,
  output logic                 irq
`endif
);

  localparam int c_aw = $clog2(DEPTH);
  localparam int c_cw = c_aw + 1;
  localparam logic [1:0] c_addr_down = 2'd0;
  localparam logic [1:0] c_addr_up   = 2'd1;
  localparam logic [1:0] c_addr_stat = 2'd2;
  localparam logic [1:0] c_addr_ctrl = 2'd3;

  logic [DATA_W-1:0] down_mem [DEPTH];
  logic [DATA_W-1:0] up_mem   [DEPTH];

  logic [c_aw-1:0] down_wr_q, down_wr_d, down_rd_q, down_rd_d;
  logic [c_aw-1:0] up_wr_q, up_wr_d, up_rd_q, up_rd_d;
  logic [c_cw-1:0] down_cnt_q, down_cnt_d, up_cnt_q, up_cnt_d;
  logic            unf_q, unf_d, ovf_q, ovf_d;
  logic [31:0]     din_q, din_d;

  logic [1:0]  w_sel;
  logic        w_rd_acc, w_wr_acc;
  logic [31:0] w_wdata;
  logic        w_down_full, w_down_ne, w_up_full, w_up_ne;
  logic        w_down_hit, w_down_push, w_ovf_evt;
  logic        w_up_hit, w_up_pop, w_unf_evt;
  logic        w_ctrl_wr, w_flush, w_clr_flags;
  logic        w_put, w_get;
  logic [31:0] w_status, w_ctrl_rd;
  logic        w_unused;

  assign w_sel    = bus.bramTargetWires_bramAddr[3:2];
  assign w_wr_acc = bus.bramTargetWires_bramEN & (|bus.bramTargetWires_bramWEN);
  assign w_rd_acc = bus.bramTargetWires_bramEN & ~(|bus.bramTargetWires_bramWEN);
  // The window aliases across the whole address space.
  assign w_unused = ^{bus.bramTargetWires_bramAddr[31:4], bus.bramTargetWires_bramAddr[1:0]};

  // Disabled byte lanes are zeroed, for both data pushes and CONTROL writes.
  for (genvar i = 0; i < DATA_W / 8; i++) begin : g_lane
    assign w_wdata[8*i +: 8] = bus.bramTargetWires_bramWEN[i] ?
                               bus.bramTargetWires_bramDout[8*i +: 8] : 8'h00;
  end

  assign w_down_full = (down_cnt_q == c_cw'(DEPTH));
  assign w_down_ne   = (down_cnt_q != '0);
  assign w_up_full   = (up_cnt_q == c_cw'(DEPTH));
  assign w_up_ne     = (up_cnt_q != '0);

  // Fullness is judged at cycle start, so a same-cycle local get never makes room.
  assign w_down_hit  = w_wr_acc & (w_sel == c_addr_down);
  assign w_down_push = w_down_hit & ~w_down_full;
  assign w_ovf_evt   = w_down_hit & w_down_full;
  assign w_up_hit    = w_rd_acc & (w_sel == c_addr_up);
  assign w_up_pop    = w_up_hit & w_up_ne;
  assign w_unf_evt   = w_up_hit & ~w_up_ne;
  assign w_ctrl_wr   = w_wr_acc & (w_sel == c_addr_ctrl);
  assign w_flush     = bus.bramTargetWires_bramRST | (w_ctrl_wr & w_wdata[0]);
  assign w_clr_flags = w_ctrl_wr & w_wdata[1];
  assign w_put       = bus.EN_msgInput_put & ~w_up_full;
  assign w_get       = bus.EN_msgOutput_get & w_down_ne;

  assign w_status = {6'b0, ovf_q, unf_q, 6'b0, w_up_ne, w_down_full,
                     8'(up_cnt_q), 8'(down_cnt_q)};

`ifdef MAILBOX_IRQ_EN
  logic irq_en_q, irq_en_d, irq_q, irq_d;
  assign w_ctrl_rd = {29'b0, irq_en_q, 2'b00};
  assign irq_en_d  = w_ctrl_wr ? w_wdata[2] : irq_en_q;
  assign irq_d     = irq_en_q & (w_up_ne | unf_q | ovf_q);
  assign irq       = irq_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
    end
  end
`else
  assign w_ctrl_rd = 32'h0;
`endif

  always_comb begin
    down_wr_d  = down_wr_q + c_aw'(w_down_push);
    down_rd_d  = down_rd_q + c_aw'(w_get);
    down_cnt_d = down_cnt_q + c_cw'(w_down_push) - c_cw'(w_get);
    up_wr_d    = up_wr_q + c_aw'(w_put);
    up_rd_d    = up_rd_q + c_aw'(w_up_pop);
    up_cnt_d   = up_cnt_q + c_cw'(w_put) - c_cw'(w_up_pop);
    // Flush overrides every same-cycle push and pop.
    if (w_flush) begin
      down_wr_d  = '0;
      down_rd_d  = '0;
      down_cnt_d = '0;
      up_wr_d    = '0;
      up_rd_d    = '0;
      up_cnt_d   = '0;
    end
    unf_d = w_clr_flags ? 1'b0 : (unf_q | w_unf_evt);
    ovf_d = w_clr_flags ? 1'b0 : (ovf_q | w_ovf_evt);
    // Read data samples pre-edge state; it holds on idle and write cycles.
    din_d = din_q;
    if (w_rd_acc) begin
      case (w_sel)
        c_addr_up:   din_d = w_up_ne ? up_mem[up_rd_q] : 32'h0;
        c_addr_stat: din_d = w_status;
        c_addr_ctrl: din_d = w_ctrl_rd;
        default:     din_d = 32'h0;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      down_wr_q  <= '0;
      down_rd_q  <= '0;
      down_cnt_q <= '0;
      up_wr_q    <= '0;
      up_rd_q    <= '0;
      up_cnt_q   <= '0;
      unf_q      <= 1'b0;
      ovf_q      <= 1'b0;
      din_q      <= 32'h0;
    end else begin
      down_wr_q  <= down_wr_d;
      down_rd_q  <= down_rd_d;
      down_cnt_q <= down_cnt_d;
      up_wr_q    <= up_wr_d;
      up_rd_q    <= up_rd_d;
      up_cnt_q   <= up_cnt_d;
      unf_q      <= unf_d;
      ovf_q      <= ovf_d;
      din_q      <= din_d;
    end
  end

  // Storage needs no reset: emptiness is carried entirely by the counts.
  always_ff @(posedge CLK) begin
    if (w_down_push) down_mem[down_wr_q] <= w_wdata;
    if (w_put)       up_mem[up_wr_q]     <= bus.msgInput_put;
  end

  assign bus.RDY_msgInput_put        = ~w_up_full;
  assign bus.RDY_msgOutput_get       = w_down_ne;
  assign bus.msgOutput_get           = w_down_ne ? down_mem[down_rd_q] : 32'h0;
  assign bus.bramTargetWires_bramDin = din_q;

`ifndef SYNTHESIS
  a_put_legal: assert property (@(posedge CLK) disable iff (!RST_N)
                                !(bus.EN_msgInput_put && !bus.RDY_msgInput_put));
  a_get_legal: assert property (@(posedge CLK) disable iff (!RST_N)
                                !(bus.EN_msgOutput_get && !bus.RDY_msgOutput_get));
`endif

endmodule
`default_nettype wire

// File: tb/tb_bram_mailbox_target.sv
`default_nettype none
// ============================================================================
// Module   : tb_bram_mailbox_target
// Purpose  : Self-checking bench for bram_mailbox_target. A queue-based
//            mailbox model predicts every output each cycle; directed steps
//            add explicit expected constants, then a randomized phase runs.
// Options  : honours MAILBOX_IRQ_EN (irq port and CONTROL bit2)
// Revision : 1.0  initial release
// ============================================================================
module tb_bram_mailbox_target;
  localparam int DEPTH = 16;

  logic CLK;
  logic RST_N;
  bram_mailbox_target_if bus();
`ifdef MAILBOX_IRQ_EN
  logic irq;
  bit   exp_irq;
`endif

  bram_mailbox_target #(.DEPTH(DEPTH), .DATA_W(32)) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .bus  (bus)
`ifdef MAILBOX_IRQ_EN
    ,
    .irq  (irq)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mq_down[$];
  logic [31:0] mq_up[$];
  bit          m_unf, m_ovf, m_irq_en;
  logic [31:0] exp_din;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_status();
    logic [31:0] s;
    s = '0;
    s[7:0]  = 8'(mq_down.size());
    s[15:8] = 8'(mq_up.size());
    s[16]   = (mq_down.size() == DEPTH);
    s[17]   = (mq_up.size() != 0);
    s[24]   = m_unf;
    s[25]   = m_ovf;
    return s;
  endfunction

  task automatic idle_inputs();
    bus.msgInput_put             = 32'h0;
    bus.EN_msgInput_put          = 1'b0;
    bus.EN_msgOutput_get         = 1'b0;
    bus.bramTargetWires_bramRST  = 1'b0;
    bus.bramTargetWires_bramAddr = 32'h0;
    bus.bramTargetWires_bramDout = 32'h0;
    bus.bramTargetWires_bramWEN  = 4'h0;
    bus.bramTargetWires_bramEN   = 1'b0;
  endtask

  task automatic model_reset();
    mq_down.delete();
    mq_up.delete();
    m_unf = 0; m_ovf = 0; m_irq_en = 0;
    exp_din = 32'h0;
`ifdef MAILBOX_IRQ_EN
    exp_irq = 0;
`endif
  endtask

  task automatic check_outputs(input string pfx);
    chk({pfx, "_rdy_put"}, {31'b0, bus.RDY_msgInput_put}, {31'b0, mq_up.size() < DEPTH});
    chk({pfx, "_rdy_get"}, {31'b0, bus.RDY_msgOutput_get}, {31'b0, mq_down.size() != 0});
    chk({pfx, "_get_data"}, bus.msgOutput_get, (mq_down.size() != 0) ? mq_down[0] : 32'h0);
    chk({pfx, "_din"}, bus.bramTargetWires_bramDin, exp_din);
`ifdef MAILBOX_IRQ_EN
    chk({pfx, "_irq"}, {31'b0, irq}, {31'b0, exp_irq});
`endif
  endtask

  // One clock cycle: drive, predict from the mailbox rules, clock, compare.
  task automatic cycle(input bit put, input logic [31:0] pdata, input bit get,
                       input bit en, input logic [31:0] addr, input logic [3:0] wen,
                       input logic [31:0] wdata, input bit brst);
    logic [31:0] md;
    logic [1:0]  sel;
    bit          rd, wr, full, flush;
    bus.msgInput_put             = pdata;
    bus.EN_msgInput_put          = put;
    bus.EN_msgOutput_get         = get;
    bus.bramTargetWires_bramRST  = brst;
    bus.bramTargetWires_bramAddr = addr;
    bus.bramTargetWires_bramDout = wdata;
    bus.bramTargetWires_bramWEN  = wen;
    bus.bramTargetWires_bramEN   = en;

    sel = addr[3:2];
    rd  = en && (wen == 4'h0);
    wr  = en && (wen != 4'h0);
    for (int i = 0; i < 4; i++) md[8*i +: 8] = wen[i] ? wdata[8*i +: 8] : 8'h00;
`ifdef MAILBOX_IRQ_EN
    exp_irq = m_irq_en && (mq_up.size() != 0 || m_unf || m_ovf);
`endif
    if (rd) begin
      case (sel)
        2'd1:    exp_din = (mq_up.size() != 0) ? mq_up[0] : 32'h0;
        2'd2:    exp_din = m_status();
        2'd3:    exp_din = m_irq_en ? 32'h4 : 32'h0;
        default: exp_din = 32'h0;
      endcase
    end
    full  = (mq_down.size() == DEPTH);
    flush = brst || (wr && sel == 2'd3 && md[0]);
    if (wr && sel == 2'd0 && full) m_ovf = 1;
    if (rd && sel == 2'd1 && mq_up.size() == 0) m_unf = 1;
    if (wr && sel == 2'd3) begin
      if (md[1]) begin m_unf = 0; m_ovf = 0; end
`ifdef MAILBOX_IRQ_EN
      m_irq_en = md[2];
`endif
    end
    if (flush) begin
      mq_down.delete();
      mq_up.delete();
    end else begin
      if (rd && sel == 2'd1 && mq_up.size() != 0) void'(mq_up.pop_front());
      if (put) mq_up.push_back(pdata);
      if (get) void'(mq_down.pop_front());
      if (wr && sel == 2'd0 && !full) mq_down.push_back(md);
    end

    @(posedge CLK);
    #1;
    idle_inputs();
    check_outputs("cyc");
  endtask

  task automatic bwr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] wen);
    cycle(0, 32'h0, 0, 1, addr, wen, data, 0);
  endtask

  task automatic brd(input logic [31:0] addr);
    cycle(0, 32'h0, 0, 1, addr, 4'h0, 32'h0, 0);
  endtask

  initial begin
    idle_inputs();
    model_reset();
    RST_N = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check_outputs("reset");
    RST_N = 1'b1;

    // 1: initiator write becomes the local get head
    bwr(32'h0, 32'h11223344, 4'hF);
    chk("t1_rdy_get", {31'b0, bus.RDY_msgOutput_get}, 32'h1);
    chk("t1_get_data", bus.msgOutput_get, 32'h11223344);
    cycle(0, 32'h0, 1, 0, 32'h0, 4'h0, 32'h0, 0);
    chk("t1_rdy_get_after", {31'b0, bus.RDY_msgOutput_get}, 32'h0);

    // 2: local put read back by the initiator
    cycle(1, 32'hA5A5A5A5, 0, 0, 32'h0, 4'h0, 32'h0, 0);
    brd(32'h4);
    chk("t2_din", bus.bramTargetWires_bramDin, 32'hA5A5A5A5);
    brd(32'h8);
    chk("t2_status", bus.bramTargetWires_bramDin, 32'h0);

    // 3: overflow on the 17th write
    for (int i = 1; i <= 16; i++) bwr(32'h0, i, 4'hF);
    brd(32'h8);
    chk("t3_status_full", bus.bramTargetWires_bramDin, 32'h00010010);
    bwr(32'h0, 32'd17, 4'hF);
    brd(32'h8);
    chk("t3_status_ovf", bus.bramTargetWires_bramDin, 32'h02010010);
    for (int i = 1; i <= 16; i++) begin
      chk("t3_drain", bus.msgOutput_get, i);
      cycle(0, 32'h0, 1, 0, 32'h0, 4'h0, 32'h0, 0);
    end
    chk("t3_no_17th", {31'b0, bus.RDY_msgOutput_get}, 32'h0);

    // 4: underflow, then clear sticky flags
    brd(32'h4);
    chk("t4_din_empty", bus.bramTargetWires_bramDin, 32'h0);
    brd(32'h8);
    chk("t4_unf_set", bus.bramTargetWires_bramDin & 32'h01000000, 32'h01000000);
    bwr(32'hC, 32'h2, 4'hF);
    brd(32'h8);
    chk("t4_flags_clr", bus.bramTargetWires_bramDin, 32'h0);

    // 5: byte-lane masking
    bwr(32'h0, 32'hDEADBEEF, 4'b0011);
    chk("t5_masked", bus.msgOutput_get, 32'h0000BEEF);
    cycle(0, 32'h0, 1, 0, 32'h0, 4'h0, 32'h0, 0);

    // 6: flush with same-cycle put; address alias through bit 4 and above
    for (int i = 0; i < 3; i++) cycle(1, 32'h100 + i, 0, 1, 32'h10, 4'hF, 32'h200 + i, 0);
    brd(32'h18);
    chk("t6_status_loaded", bus.bramTargetWires_bramDin, 32'h00020303);
    cycle(1, 32'h999, 0, 0, 32'h0, 4'h0, 32'h0, 1);
    chk("t6_rdy_put", {31'b0, bus.RDY_msgInput_put}, 32'h1);
    chk("t6_rdy_get", {31'b0, bus.RDY_msgOutput_get}, 32'h0);
    brd(32'h8);
    chk("t6_status_flushed", bus.bramTargetWires_bramDin, 32'h0);

    // Read in a flush cycle returns pre-flush data; CONTROL bit0 flush
    cycle(1, 32'h77, 0, 0, 32'h0, 4'h0, 32'h0, 0);
    cycle(0, 32'h0, 0, 1, 32'h4, 4'h0, 32'h0, 1);
    chk("flush_read", bus.bramTargetWires_bramDin, 32'h77);
    bwr(32'h0, 32'h55, 4'hF);
    bwr(32'hC, 32'h1, 4'hF);
    chk("ctrl_flush", {31'b0, bus.RDY_msgOutput_get}, 32'h0);

`ifdef MAILBOX_IRQ_EN
    bwr(32'hC, 32'h4, 4'hF);
    brd(32'hC);
    chk("irq_ctrl_rd", bus.bramTargetWires_bramDin, 32'h4);
    cycle(1, 32'h1234, 0, 0, 32'h0, 4'h0, 32'h0, 0);
    chk("irq_low", {31'b0, irq}, 32'h0);
    cycle(0, 32'h0, 0, 0, 32'h0, 4'h0, 32'h0, 0);
    chk("irq_high", {31'b0, irq}, 32'h1);
    bwr(32'hC, 32'h1, 4'hF);
`else
    bwr(32'hC, 32'h4, 4'hF);
    brd(32'hC);
    chk("ctrl_bit2_ignored", bus.bramTargetWires_bramDin, 32'h0);
`endif

    // Asynchronous reset during an in-flight read
    cycle(1, 32'hCAFE0001, 0, 0, 32'h0, 4'h0, 32'h0, 0);
    bus.bramTargetWires_bramEN   = 1'b1;
    bus.bramTargetWires_bramAddr = 32'h4;
    #2;
    RST_N = 1'b0;
    #1;
    idle_inputs();
    model_reset();
    check_outputs("async_rst");
    @(posedge CLK);
    #1;
    check_outputs("async_rst_hold");
    RST_N = 1'b1;

    // Randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      bit          p, g, e, b;
      logic [31:0] a, d;
      logic [3:0]  w;
      p = ($urandom_range(0, 2) == 0) && (mq_up.size() < DEPTH);
      g = ($urandom_range(0, 3) == 0) && (mq_down.size() != 0);
      e = ($urandom_range(0, 3) != 0);
      a = $urandom;
      w = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      d = $urandom;
      if (a[3:2] == 2'd3 && $urandom_range(0, 7) != 0) d[0] = 1'b0;
      b = ($urandom_range(0, 80) == 0);
      cycle(p, $urandom, g, e, a, w, d, b);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout observed=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
`default_nettype wire
